sync_debounce: RTL and testbench
================================

Name: sync_debounce

Overview:
- Parametrised multi-channel input conditioner for asynchronous push-button and enable inputs (start, clear, lap, ...).
- Each channel has:
  - an N-stage synchroniser,
  - a counter-based debouncer,
  - registered rise/fall pulse outputs,
  - an optional toggle latch.
- Sits between the board pins and the stop-watch control FSM. It replaces the fixed two-input synchroniser.

Parameters:
- CH, 2: number of independent input channels (≥1).
- SYNC_STAGES, 2: synchroniser flop depth per channel (≥2).
- DB_LIMIT, 10: consecutive clocks a new synchronised level must persist before acceptance (1 to 65535). Counter width is $clog2(DB_LIMIT+1), derived internally.

Ports:
- I_CLK, input, 1: system clock.
- I_RST, input, 1: asynchronous active-high reset.
- I_IN, input, CH: raw asynchronous inputs; bit i is channel i.
- I_TOGGLE_CLR, input, CH: synchronous clear of the toggle state, per channel.
- O_LEVEL, output, CH: debounced stable level.
- O_RISE, output, CH: one-clock pulse when O_LEVEL goes 0→1.
- O_FALL, output, CH: one-clock pulse when O_LEVEL goes 1→0.
- O_TOGGLE, output, CH: toggle state; see Optional Feature.

Behaviour:
- One clock (I_CLK) and one asynchronous active-high reset (I_RST).
- I_RST high clears every flop to 0 immediately, without waiting for a clock edge. This covers sync stages, debounce counters, O_LEVEL, O_RISE, O_FALL and O_TOGGLE. This holds mid-operation too: any count in progress is lost and any pulse is cut.
- All outputs are registered. There is no combinational path from any input to any output.
- Synchroniser: I_IN[i] passes through SYNC_STAGES flops. The output of the last stage is s[i].
- Debouncer, per channel, evaluated on each rising edge (L = O_LEVEL[i], c = counter):
  - s == L: c ← 0.
  - s != L and c == DB_LIMIT−1: L ← s, c ← 0, and the matching O_RISE/O_FALL bit goes to 1 for exactly one clock.
  - s != L otherwise: c ← c+1.
- Latency:
  - Input settles before clock edge 1.
  - s changes at edge SYNC_STAGES.
  - O_LEVEL and the pulse change at edge SYNC_STAGES+DB_LIMIT. With defaults this is edge 12.
- Glitch handling:
  - Any return of s to L before acceptance resets c to 0.
  - A pulse of s shorter than DB_LIMIT clocks produces no output change.
- DB_LIMIT=1: a new level is accepted on the first clock after s differs. Latency is SYNC_STAGES+1.
- O_RISE and O_FALL are never both high on one channel in the same clock. Consecutive pulses on one channel are at least DB_LIMIT clocks apart.
- Input held high through reset release: O_LEVEL rises SYNC_STAGES+DB_LIMIT clocks after I_RST falls, with one O_RISE pulse.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.

Optional Feature:
- Macro: SYNC_DEBOUNCE_TOGGLE_EN.
- Defined: O_TOGGLE[i] inverts on every cycle in which the debouncer asserts the rise pulse. This uses the same edge as the O_RISE register update, so O_TOGGLE changes in the same cycle O_RISE goes high. It implements start/stop on a single button.
  - I_TOGGLE_CLR[i] high at a clock edge forces O_TOGGLE[i] ← 0.
  - A clear has priority over a simultaneous rise, so the result is 0.
- Undefined: O_TOGGLE is constant 0 and I_TOGGLE_CLR is ignored. No toggle flops are synthesised.

Test Plan (defaults: CH=2, SYNC_STAGES=2, DB_LIMIT=10):
- Reset: I_RST=1 with I_IN=2'b11, then release.
  - While reset is high, all outputs are 0.
  - After release, O_LEVEL=2'b11 at edge 12.
  - O_RISE=2'b11 for exactly 1 clock.
- Clean press: I_IN[0] 0→1 held for 30 clocks, then 1→0.
  - O_RISE[0] pulses at edge 12 after the rise.
  - O_FALL[0] pulses at edge 12 after the fall.
  - O_LEVEL[0] is high for exactly 30 clocks.
- Bounce: I_IN[1] toggled high 3 clocks / low 2 clocks ×4, then held high.
  - Exactly one O_RISE[1] pulse, 12 clocks after the final rise.
  - No O_FALL[1].
- Glitch: I_IN[0] high for 9 clocks only.
  - O_LEVEL[0], O_RISE[0] and O_FALL[0] stay 0.
- Toggle (SYNC_DEBOUNCE_TOGGLE_EN defined): two clean presses on channel 0.
  - O_TOGGLE[0] goes 0→1→0.
  - Asserting I_TOGGLE_CLR[0] in the same cycle as a rise pulse leaves O_TOGGLE[0]=0.
- Reset mid-count: I_IN[0] held high, I_RST pulsed at clock 6 after the rise.
  - O_LEVEL[0] rises 12 clocks after reset release, not before.

Source files
------------

// File: rtl/sync_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sync_debounce
// Purpose  : Multi-channel input conditioner for asynchronous push-buttons and
//            enable inputs. Each channel has an N-stage synchroniser, a
//            counter-based debouncer and registered rise/fall pulses. It can
//            optionally add a toggle latch, enabled by the compile-time macro
//            SYNC_DEBOUNCE_TOGGLE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sync_debounce #(
    parameter int CH          = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DB_LIMIT    = 10
) (
    input  logic          I_CLK,
    input  logic          I_RST,
    input  logic [CH-1:0] I_IN,
    input  logic [CH-1:0] I_TOGGLE_CLR,
    output logic [CH-1:0] O_LEVEL,
    output logic [CH-1:0] O_RISE,
    output logic [CH-1:0] O_FALL,
    output logic [CH-1:0] O_TOGGLE
);

    // Wide enough to hold DB_LIMIT. The counter itself never exceeds DB_LIMIT-1.
    localparam int                 c_CNT_W    = $clog2(DB_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DB_LIMIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic [c_CNT_W-1:0]     r_cnt;
            logic                   r_level;
            logic                   r_rise;
            logic                   r_fall;
            logic                   w_sync;
            logic                   w_differ;
            logic                   w_accept;

            // The last synchroniser stage is the only version of the pin the debouncer sees.
            assign w_sync   = r_sync[SYNC_STAGES-1];
            assign w_differ = w_sync ^ r_level;
            // The new level has persisted long enough and is taken on this edge.
            assign w_accept = w_differ && (r_cnt == c_CNT_LAST);

            // Metastability synchroniser: shift the raw pin toward the MSB.
            always_ff @(posedge I_CLK or posedge I_RST) begin
                if (I_RST) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], I_IN[gi]};
                end
            end

            // Debounce counter. Any return to the current level restarts the count.
            always_ff @(posedge I_CLK or posedge I_RST) begin
                if (I_RST) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end else if (!w_differ || w_accept) begin
                    r_cnt   <= '0;
                    if (w_accept) begin
                        r_level <= w_sync;
                    end
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end

            // Registered edge pulses. Each pulse is high only in the cycle the level changes.
            always_ff @(posedge I_CLK or posedge I_RST) begin
                if (I_RST) begin
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    r_rise <= w_accept &&  w_sync;
                    r_fall <= w_accept && !w_sync;
                end
            end

            assign O_LEVEL[gi] = r_level;
            assign O_RISE[gi]  = r_rise;
            assign O_FALL[gi]  = r_fall;

`ifdef SYNC_DEBOUNCE_TOGGLE_EN
            logic r_toggle;

            // Start/stop latch. It flips on the same edge that raises the rise pulse, and a clear wins.
            always_ff @(posedge I_CLK or posedge I_RST) begin
                if (I_RST) begin
                    r_toggle <= 1'b0;
                end else if (I_TOGGLE_CLR[gi]) begin
                    r_toggle <= 1'b0;
                end else if (w_accept && w_sync) begin
                    r_toggle <= ~r_toggle;
                end
            end

            assign O_TOGGLE[gi] = r_toggle;
`else
            assign O_TOGGLE[gi] = 1'b0;
`endif
        end
    endgenerate

`ifdef SYNC_DEBOUNCE_TOGGLE_EN
`else
    // Without the toggle latch the clear inputs have no function.
    logic w_unused_toggle_clr;
    assign w_unused_toggle_clr = ^I_TOGGLE_CLR;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_debounce
// Purpose  : Self-checking bench for sync_debounce with default parameters.
//            Directed scenarios are followed by randomized input traffic.
//            All of it is compared against a sliding-window reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_debounce;

    localparam int CH  = 2;
    localparam int SS  = 2;
    localparam int DB  = 10;
    localparam int LAT = SS + DB;
`ifdef SYNC_DEBOUNCE_TOGGLE_EN
    localparam bit TOG = 1'b1;
`else
    localparam bit TOG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] r_in;
    logic [CH-1:0] r_tclr;
    logic [CH-1:0] w_level;
    logic [CH-1:0] w_rise;
    logic [CH-1:0] w_fall;
    logic [CH-1:0] w_toggle;

    sync_debounce #(.CH(CH), .SYNC_STAGES(SS), .DB_LIMIT(DB)) u_dut (
        .I_CLK        (clk),
        .I_RST        (rst),
        .I_IN         (r_in),
        .I_TOGGLE_CLR (r_tclr),
        .O_LEVEL      (w_level),
        .O_RISE       (w_rise),
        .O_FALL       (w_fall),
        .O_TOGGLE     (w_toggle)
    );

    always #5 clk = ~clk;

    // Reference model. It keeps every raw sample taken since reset. A channel accepts
    // a new level on an edge when the DB most recent synchronised samples all differ
    // from its current level. The synchronised sample seen before edge n is the raw
    // value sampled at edge n-SS.
    logic [CH-1:0] m_hist[$];
    logic [CH-1:0] m_level, m_rise, m_fall, m_tog;

    int n_checks = 0;
    int n_errors = 0;
    int t        = 0;
    int mon_ch   = 0;
    int n_hi, n_rise, n_fall, last_rise_t, last_fall_t, t0, t1;
    int hold[CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        m_level = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_tog   = '0;
    endtask

    task automatic model_edge();
        int  n;
        int  idx;
        logic b;
        logic all_diff;
        m_hist.push_back(r_in);
        n = m_hist.size();
        for (int ch = 0; ch < CH; ch++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DB; j++) begin
                idx = n - SS - 1 - j;
                b   = (idx >= 0) ? m_hist[idx][ch] : 1'b0;
                if (b == m_level[ch]) all_diff = 1'b0;
            end
            m_rise[ch] = all_diff & ~m_level[ch];
            m_fall[ch] = all_diff &  m_level[ch];
            if (all_diff) m_level[ch] = ~m_level[ch];
            if (TOG) begin
                if (r_tclr[ch])      m_tog[ch] = 1'b0;
                else if (m_rise[ch]) m_tog[ch] = ~m_tog[ch];
            end
        end
    endtask

    task automatic compare_all();
        check("level",  32'(w_level),  32'(m_level));
        check("rise",   32'(w_rise),   32'(m_rise));
        check("fall",   32'(w_fall),   32'(m_fall));
        check("toggle", 32'(w_toggle), 32'(m_tog));
        check("rise_fall_excl", 32'(w_rise & w_fall), 0);
    endtask

    task automatic reset_counts(input int ch);
        mon_ch      = ch;
        n_hi        = 0;
        n_rise      = 0;
        n_fall      = 0;
        last_rise_t = -1;
        last_fall_t = -1;
    endtask

    // One clock: update the model at the edge, then sample the DUT 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        t++;
        if (w_level[mon_ch]) n_hi++;
        if (w_rise[mon_ch]) begin n_rise++; last_rise_t = t; end
        if (w_fall[mon_ch]) begin n_fall++; last_fall_t = t; end
        compare_all();
    endtask

    // Asynchronous reset pulse that starts between edges and lasts n edges.
    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("reset_async_zero", 32'({w_level, w_rise, w_fall, w_toggle}), 0);
        repeat (n) tick();
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b0;
        r_in   = '0;
        r_tclr = '0;
        model_reset();
        reset_counts(0);

        // Reset with both inputs held high, then release.
        #1;
        r_in = 2'b11;
        do_reset(3);
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            if (k == LAT - 1) check("rst_release_early", 32'(w_level), 0);
            if (k == LAT) begin
                check("rst_release_level", 32'(w_level), 3);
                check("rst_release_rise",  32'(w_rise),  3);
            end
            if (k == LAT + 1) check("rst_release_rise_once", 32'(w_rise), 0);
        end

        // Clean press on channel 0 held for 30 clocks.
        r_in = 2'b00;
        repeat (LAT + 5) tick();
        reset_counts(0);
        t0 = t;
        r_in[0] = 1'b1;
        repeat (30) tick();
        t1 = t;
        r_in[0] = 1'b0;
        repeat (LAT + 5) tick();
        check("press_rise_latency", 32'(last_rise_t - t0), LAT);
        check("press_fall_latency", 32'(last_fall_t - t1), LAT);
        check("press_high_clocks",  32'(n_hi), 30);
        check("press_rise_count",   32'(n_rise), 1);
        check("press_fall_count",   32'(n_fall), 1);

        // Bounce on channel 1: 3 high / 2 low, four times, then held high.
        reset_counts(1);
        for (int b = 0; b < 4; b++) begin
            r_in[1] = 1'b1;
            repeat (3) tick();
            r_in[1] = 1'b0;
            repeat (2) tick();
        end
        t0 = t;
        r_in[1] = 1'b1;
        repeat (LAT + 8) tick();
        check("bounce_rise_count",   32'(n_rise), 1);
        check("bounce_rise_latency", 32'(last_rise_t - t0), LAT);
        check("bounce_fall_count",   32'(n_fall), 0);
        r_in[1] = 1'b0;
        repeat (LAT + 5) tick();

        // A 9-clock glitch is rejected.
        reset_counts(0);
        r_in[0] = 1'b1;
        repeat (DB - 1) tick();
        r_in[0] = 1'b0;
        repeat (LAT + 5) tick();
        check("glitch_rise_count", 32'(n_rise), 0);
        check("glitch_fall_count", 32'(n_fall), 0);
        check("glitch_high",       32'(n_hi), 0);

        // A pulse of exactly DB clocks is accepted and lasts DB clocks.
        reset_counts(0);
        r_in[0] = 1'b1;
        repeat (DB) tick();
        r_in[0] = 1'b0;
        repeat (LAT + 12) tick();
        check("limit_rise_count", 32'(n_rise), 1);
        check("limit_fall_count", 32'(n_fall), 1);
        check("limit_high",       32'(n_hi), DB);

        // Toggle: two presses, then a clear that coincides with a rise.
        r_tclr = 2'b11;
        tick();
        r_tclr = 2'b00;
        r_in[0] = 1'b1;
        repeat (LAT + 3) tick();
        check("toggle_first_press", 32'(w_toggle[0]), 32'(TOG));
        r_in[0] = 1'b0;
        repeat (LAT + 3) tick();
        r_in[0] = 1'b1;
        repeat (LAT + 3) tick();
        check("toggle_second_press", 32'(w_toggle[0]), 0);
        r_in[0] = 1'b0;
        repeat (LAT + 3) tick();
        r_in[0] = 1'b1;
        repeat (LAT - 1) tick();
        r_tclr[0] = 1'b1;
        tick();
        check("toggle_clr_rise_pulse", 32'(w_rise[0]), 1);
        check("toggle_clr_priority",   32'(w_toggle[0]), 0);
        r_tclr = 2'b00;
        r_in[0] = 1'b0;
        repeat (LAT + 3) tick();

        // Reset in the middle of a count: the count is lost.
        r_in = 2'b01;
        repeat (6) tick();
        do_reset(2);
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k == LAT - 1) check("midreset_early", 32'(w_level[0]), 0);
            if (k == LAT) begin
                check("midreset_level", 32'(w_level[0]), 1);
                check("midreset_rise",  32'(w_rise[0]),  1);
            end
        end
        // Reset while the rise pulse is high cuts the pulse.
        do_reset(1);
        check("reset_cuts_pulse", 32'(w_rise), 0);
        repeat (LAT + 3) tick();

        // Randomized traffic on all channels with occasional toggle clears.
        for (int ch = 0; ch < CH; ch++) hold[ch] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < CH; ch++) begin
                if (hold[ch] == 0) begin
                    r_in[ch] = ~r_in[ch];
                    hold[ch] = int'($urandom_range(1, 2 * DB + 4));
                end else begin
                    hold[ch]--;
                end
            end
            r_tclr = ($urandom_range(0, 15) == 0) ? CH'($urandom()) : '0;
            if (c == 1700) do_reset(1);
            else           tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
